// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, runs the imem req/ack handshake,
// presents one fetched word at a time and turns a hung memory into a sticky error.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        fetch_err_o
);

  localparam int            WW   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, ipc_q, ipc_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          req_q, req_d, vld_q, vld_d, err_q, err_d, flush_q, flush_d;
  logic [31:0]   tgt;
  logic          unused_lsb;

  assign tgt        = {redirect_pc_i[31:2], 2'b00};
  assign unused_lsb = ^redirect_pc_i[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    wait_d  = wait_q;
    req_d   = req_q;
    vld_d   = vld_q;
    err_d   = err_q;
    flush_d = flush_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid_i) pc_d = tgt;
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc_d;
        wait_d  = '0;
      end
      REQ: begin
        if (imem_ack_i) begin
          if (flush_q || redirect_valid_i) begin
            // Word belongs to the old stream; re-issue at the redirect target.
            if (redirect_valid_i) pc_d = tgt;
            flush_d = 1'b0;
            addr_d  = pc_d;
            wait_d  = '0;
          end else begin
            instr_d = imem_rdata_i;
            ipc_d   = addr_q;
            vld_d   = 1'b1;
            pc_d    = pc_q + 32'd4;
            req_d   = 1'b0;
            state_d = HOLD;
          end
        end else begin
          // wait_cnt keeps running across a redirect: it times the bus transaction.
          if (redirect_valid_i) begin
            pc_d    = tgt;
            flush_d = 1'b1;
          end
          if (wait_q == WMAX) begin
            state_d = ERR;
            err_d   = 1'b1;
            req_d   = 1'b0;
            vld_d   = 1'b0;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
      end
      HOLD: begin
        if (redirect_valid_i || !stall_i) begin
          if (redirect_valid_i) pc_d = tgt;
          vld_d   = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_d;
          wait_d  = '0;
          state_d = REQ;
        end
      end
      ERR: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= NOP;
      ipc_q   <= '0;
      wait_q  <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      flush_q <= flush_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = vld_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign fetch_err_o   = err_q;

endmodule
